// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code-set-2 key event decoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXT       = 3'd1,
        ST_BREAK     = 3'd2,
        ST_EXT_BREAK = 3'd3,
        ST_SKIP      = 3'd4
    } parse_state_t;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BREAK = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    localparam logic [7:0] ERR_00 = 8'h00;
    localparam logic [7:0] ERR_AA = 8'hAA;
    localparam logic [7:0] ERR_FA = 8'hFA;
    localparam logic [7:0] ERR_FE = 8'hFE;
    localparam logic [7:0] ERR_FF = 8'hFF;

    // Bytes that follow the leading E1 of the Pause make sequence.
    localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

    localparam int EVT_CODE_W = 8;
    localparam int EVT_W      = 10;

    typedef struct packed {
        logic                  make;
        logic                  ext;
        logic [EVT_CODE_W-1:0] code;
    } key_evt_t;

    function automatic logic is_error_code(input logic [7:0] b);
        logic r;
        case (b)
            ERR_00, ERR_AA, ERR_FA, ERR_FE, ERR_FF: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_event_decoder_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; head is
// readable whenever the FIFO is non-empty.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Gate requests: a pop frees a slot, so a full FIFO may accept a push in the same cycle.
    always_comb begin
        do_pop_s  = pop && (count_r != {(AW+1){1'b0}});
        do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage; cleared on reset so the head fields read as zero after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign count    = count_r;
    assign full     = (count_r == FULL_CNT);
    assign empty    = (count_r == {(AW+1){1'b0}});

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 byte stream to make/break event decoder with held-key bitmap,
// optional typematic-repeat suppression and a buffered event queue.
module ps2_key_event_decoder
    import ps2_pkg::*;
#(
    parameter int                    FIFO_DEPTH  = 8,
    parameter int                    KEY_COUNT   = 4,
    parameter logic [KEY_COUNT*9-1:0] KEY_MAP    = {9'h174, 9'h16B, 9'h172, 9'h175},
    parameter int                    DROP_REPEAT = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          key_en,
    input  logic [7:0]                    key_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic                          evt_make,
    output logic                          evt_ext,
    output logic [7:0]                    evt_code,
    output logic [KEY_COUNT-1:0]          held,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    parse_state_t         state_r;
    parse_state_t         state_nxt_s;
    logic [2:0]           skip_cnt_r;
    logic [2:0]           skip_cnt_nxt_s;
    logic                 emit_s;
    key_evt_t             emit_evt_s;
    logic [KEY_COUNT-1:0] match_s;
    logic [KEY_COUNT-1:0] held_r;
    logic                 suppress_s;
    logic                 push_req_s;
    logic                 pop_s;
    logic                 ovf_set_s;
    logic                 overflow_r;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    key_evt_t             head_s;

    // Parser state and Pause skip counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            skip_cnt_r <= 3'd0;
        end else begin
            state_r    <= state_nxt_s;
            skip_cnt_r <= skip_cnt_nxt_s;
        end
    end

    // Parser next state; error codes inside a prefix sequence abandon it.
    always_comb begin
        state_nxt_s    = state_r;
        skip_cnt_nxt_s = skip_cnt_r;
        if (key_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (key_data == PFX_EXT) begin
                        state_nxt_s = ST_EXT;
                    end else if (key_data == PFX_BREAK) begin
                        state_nxt_s = ST_BREAK;
                    end else if (key_data == PFX_PAUSE) begin
                        state_nxt_s    = ST_SKIP;
                        skip_cnt_nxt_s = PAUSE_SKIP_LEN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (key_data == PFX_BREAK) begin
                        state_nxt_s = ST_EXT_BREAK;
                    end else if (key_data == PFX_EXT) begin
                        state_nxt_s = ST_EXT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    if (key_data == PFX_EXT) begin
                        state_nxt_s = ST_EXT_BREAK;
                    end else if (key_data == PFX_BREAK) begin
                        state_nxt_s = ST_BREAK;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_EXT_BREAK: begin
                    if ((key_data == PFX_EXT) || (key_data == PFX_BREAK)) begin
                        state_nxt_s = ST_EXT_BREAK;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SKIP: begin
                    skip_cnt_nxt_s = (skip_cnt_r == 3'd0) ? 3'd0 : skip_cnt_r - 3'd1;
                    if (skip_cnt_r <= 3'd1) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_SKIP;
                    end
                end
                default: begin
                    state_nxt_s    = ST_IDLE;
                    skip_cnt_nxt_s = 3'd0;
                end
            endcase
        end else begin
            state_nxt_s    = state_r;
            skip_cnt_nxt_s = skip_cnt_r;
        end
    end

    // Parser outputs: one event per completed sequence.
    always_comb begin
        emit_s     = 1'b0;
        emit_evt_s = '{make: 1'b0, ext: 1'b0, code: 8'h00};
        if (key_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (key_data == PFX_PAUSE) begin
                        emit_s     = 1'b1;
                        emit_evt_s = '{make: 1'b1, ext: 1'b0, code: PFX_PAUSE};
                    end else if ((key_data != PFX_EXT) && (key_data != PFX_BREAK) &&
                                 !is_error_code(key_data)) begin
                        emit_s     = 1'b1;
                        emit_evt_s = '{make: 1'b1, ext: 1'b0, code: key_data};
                    end else begin
                        emit_s = 1'b0;
                    end
                end
                ST_EXT, ST_BREAK, ST_EXT_BREAK: begin
                    if ((key_data != PFX_EXT) && (key_data != PFX_BREAK) &&
                        !is_error_code(key_data)) begin
                        emit_s     = 1'b1;
                        emit_evt_s = '{make: (state_r == ST_EXT),
                                       ext:  (state_r != ST_BREAK),
                                       code: key_data};
                    end else begin
                        emit_s = 1'b0;
                    end
                end
                default: begin
                    emit_s = 1'b0;
                end
            endcase
        end else begin
            emit_s = 1'b0;
        end
    end

    // Tracked-key match, repeat filter and queue admission.
    always_comb begin
        match_s = {KEY_COUNT{1'b0}};
        for (int i = 0; i < KEY_COUNT; i++) begin
            match_s[i] = emit_s && ({emit_evt_s.ext, emit_evt_s.code} == KEY_MAP[9*i +: 9]);
        end
        suppress_s = (DROP_REPEAT != 0) && emit_evt_s.make && ((match_s & held_r) != {KEY_COUNT{1'b0}});
        push_req_s = emit_s && !suppress_s;
        pop_s      = !fifo_empty_s && evt_ready;
        ovf_set_s  = push_req_s && fifo_full_s && !pop_s;
    end

    // Held bitmap follows every decoded event, queued or not.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held_r <= {KEY_COUNT{1'b0}};
        end else begin
            for (int i = 0; i < KEY_COUNT; i++) begin
                if (match_s[i]) begin
                    held_r[i] <= emit_evt_s.make;
                end
            end
        end
    end

    // Sticky overflow; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end else if (clear_overflow) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_req_s),
        .push_data (emit_evt_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .count     (evt_count),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign evt_valid = !fifo_empty_s;
    assign evt_make  = head_s.make;
    assign evt_ext   = head_s.ext;
    assign evt_code  = head_s.code;
    assign held      = held_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed self-checking bench for ps2_key_event_decoder with default parameters.
module tb_ps2_key_event_decoder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       key_en = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic       evt_make;
    logic       evt_ext;
    logic [7:0] evt_code;
    logic [3:0] held;
    logic [3:0] evt_count;
    logic       overflow;
    logic       clear_overflow = 1'b0;

    int errors = 0;
    int checks = 0;

    ps2_key_event_decoder dut (
        .clk            (clk),
        .resetn         (resetn),
        .key_en         (key_en),
        .key_data       (key_data),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_make       (evt_make),
        .evt_ext        (evt_ext),
        .evt_code       (evt_code),
        .held           (held),
        .evt_count      (evt_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the next negedge with the byte consumed.
    task automatic send(input logic [7:0] b);
        key_en   = 1'b1;
        key_data = b;
        @(negedge clk);
        key_en   = 1'b0;
        key_data = 8'h00;
    endtask

    task automatic test_reset();
        logic [16:0] got;
        got = {evt_valid, evt_make, evt_ext, evt_code, held, overflow, evt_count == 4'd0 ? 1'b0 : 1'b1};
        checks++;
        if (got !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", got, 17'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (evt_count !== 4'd0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: count=%0d valid=%b expected 0/0", evt_count, evt_valid);
        end
    endtask

    task automatic test_basic();
        evt_ready = 1'b1;
        send(8'h1D);
        checks++;
        if ({evt_valid, evt_make, evt_ext, evt_code, held} !== {3'b110, 8'h1D, 4'h0}) begin
            errors++;
            $display("FAIL basic_make: got v=%b m=%b e=%b c=%h held=%b expected 1 1 0 1d 0000",
                     evt_valid, evt_make, evt_ext, evt_code, held);
        end
        send(8'hF0);
        checks++;
        if (evt_valid !== 1'b0 || evt_count !== 4'd0) begin
            errors++;
            $display("FAIL basic_popped: got v=%b count=%0d expected 0 0", evt_valid, evt_count);
        end
        send(8'h1D);
        checks++;
        if ({evt_valid, evt_make, evt_ext, evt_code, held} !== {3'b100, 8'h1D, 4'h0}) begin
            errors++;
            $display("FAIL basic_break: got v=%b m=%b e=%b c=%h held=%b expected 1 0 0 1d 0000",
                     evt_valid, evt_make, evt_ext, evt_code, held);
        end
        @(negedge clk);
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drained: got v=%b expected 0", evt_valid);
        end
    endtask

    task automatic test_ext_repeat();
        logic [9:0] exp_evt [2];
        exp_evt[0] = {2'b11, 8'h75};
        exp_evt[1] = {2'b01, 8'h75};
        send(8'hE0);
        checks++;
        if (held !== 4'b0000) begin
            errors++;
            $display("FAIL ext_held_before: got %b expected 0000", held);
        end
        send(8'h75);
        checks++;
        if (held !== 4'b0001 || evt_count !== 4'd1) begin
            errors++;
            $display("FAIL ext_first_make: held=%b count=%0d expected 0001 1", held, evt_count);
        end
        send(8'hE0);
        send(8'h75);
        checks++;
        if (held !== 4'b0001 || evt_count !== 4'd1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ext_repeat_dropped: held=%b count=%0d ovf=%b expected 0001 1 0",
                     held, evt_count, overflow);
        end
        send(8'hE0);
        send(8'hF0);
        checks++;
        if (held !== 4'b0001) begin
            errors++;
            $display("FAIL ext_held_mid_break: got %b expected 0001", held);
        end
        send(8'h75);
        checks++;
        if (held !== 4'b0000 || evt_count !== 4'd2) begin
            errors++;
            $display("FAIL ext_break: held=%b count=%0d expected 0000 2", held, evt_count);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({evt_valid, evt_make, evt_ext, evt_code} !== {1'b1, exp_evt[i]}) begin
                errors++;
                $display("FAIL ext_drain%0d: got v=%b m=%b e=%b c=%h expected %h",
                         i, evt_valid, evt_make, evt_ext, evt_code, {1'b1, exp_evt[i]});
            end
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL ext_empty: got v=%b expected 0", evt_valid);
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [9];
        logic [9:0] exp_evt [2];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
        exp_evt[0] = {2'b10, 8'hE1};
        exp_evt[1] = {2'b10, 8'h1C};
        for (int i = 0; i < 9; i++) begin
            send(seq[i]);
        end
        checks++;
        if (evt_count !== 4'd2 || held !== 4'b0000) begin
            errors++;
            $display("FAIL pause_count: count=%0d held=%b expected 2 0000", evt_count, held);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({evt_valid, evt_make, evt_ext, evt_code} !== {1'b1, exp_evt[i]}) begin
                errors++;
                $display("FAIL pause_drain%0d: got v=%b m=%b e=%b c=%h expected %h",
                         i, evt_valid, evt_make, evt_ext, evt_code, {1'b1, exp_evt[i]});
            end
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            send(8'(i));
            if (i == 8) begin
                checks++;
                if (evt_count !== 4'd8 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full: count=%0d ovf=%b expected 8 0", evt_count, overflow);
                end
            end
        end
        checks++;
        if (evt_count !== 4'd8 || overflow !== 1'b1 || evt_code !== 8'h01) begin
            errors++;
            $display("FAIL ovf_set: count=%0d ovf=%b head=%h expected 8 1 01",
                     evt_count, overflow, evt_code);
        end
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_code [8];
        exp_code = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
        evt_ready = 1'b1;
        send(8'h0A);
        evt_ready = 1'b0;
        checks++;
        if (evt_count !== 4'd8 || overflow !== 1'b0 || evt_code !== 8'h02) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d ovf=%b head=%h expected 8 0 02",
                     evt_count, overflow, evt_code);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({evt_valid, evt_make, evt_ext, evt_code} !== {3'b110, exp_code[i]}) begin
                errors++;
                $display("FAIL order%0d: got v=%b m=%b e=%b c=%h expected 1 1 0 %h",
                         i, evt_valid, evt_make, evt_ext, evt_code, exp_code[i]);
            end
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
        send(8'hE0);
        send(8'hAA);
        checks++;
        if (evt_count !== 4'd0) begin
            errors++;
            $display("FAIL ext_error_no_event: count=%0d expected 0", evt_count);
        end
        send(8'h33);
        checks++;
        if ({evt_valid, evt_make, evt_ext, evt_code, evt_count} !== {3'b110, 8'h33, 4'd1}) begin
            errors++;
            $display("FAIL ext_error_idle: got v=%b m=%b e=%b c=%h n=%0d expected 1 1 0 33 1",
                     evt_valid, evt_make, evt_ext, evt_code, evt_count);
        end
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        send(8'h11);
        send(8'h12);
        send(8'h13);
        send(8'hE0);
        send(8'hF0);
        checks++;
        if (evt_count !== 4'd3) begin
            errors++;
            $display("FAIL prereset_count: got %0d expected 3", evt_count);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({evt_valid, evt_make, evt_ext, evt_code, held, overflow, evt_count} !== 20'd0) begin
            errors++;
            $display("FAIL async_reset: v=%b m=%b e=%b c=%h held=%b ovf=%b n=%0d expected all 0",
                     evt_valid, evt_make, evt_ext, evt_code, held, overflow, evt_count);
        end
        @(negedge clk);
        resetn = 1'b1;
        send(8'h75);
        checks++;
        if ({evt_valid, evt_make, evt_ext, evt_code, evt_count, held} !== {3'b110, 8'h75, 4'd1, 4'h0}) begin
            errors++;
            $display("FAIL post_reset_idle: v=%b m=%b e=%b c=%h n=%0d held=%b expected 1 1 0 75 1 0000",
                     evt_valid, evt_make, evt_ext, evt_code, evt_count, held);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_ext_repeat();
        test_pause();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
